// File: rtl/scarv_soc_pkg.sv
// Shared types for the SoC peripheral-port arbiter: requester IDs and the
// selection FSM encoding.
package scarv_soc_pkg;

  typedef logic periph_arb_id_t;

  localparam periph_arb_id_t ARB_R0 = 1'b0;
  localparam periph_arb_id_t ARB_R1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } periph_arb_state_t;

endpackage

// File: rtl/scarv_soc_arb_id_fifo.sv
// Owner-ID FIFO: remembers which requester issued each granted transaction so
// the in-order responses can be steered back.
module scarv_soc_arb_id_fifo
  import scarv_soc_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic           g_clk,
  input  logic           g_resetn,
  input  logic           push,
  input  periph_arb_id_t push_id,
  input  logic           pop,
  output periph_arb_id_t head,
  output logic           full,
  output logic           empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  periph_arb_id_t [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_id;
      wr_ptr_d        = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
    end
    // Simultaneous push and pop leaves the occupancy untouched.
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/scarv_soc_periph_arb.sv
// Two-requester arbiter for the peripheral memory port. Selection is held until
// the device grants; responses are steered by the owner FIFO with zero latency.
module scarv_soc_periph_arb
  import scarv_soc_pkg::*;
#(
  parameter int OUTSTANDING = 2,
  parameter int AW          = 32
) (
  input  logic          g_clk,
  input  logic          g_resetn,

  input  logic          memif_r0_req,
  output logic          memif_r0_gnt,
  input  logic          memif_r0_wen,
  input  logic [3:0]    memif_r0_strb,
  input  logic [31:0]   memif_r0_wdata,
  input  logic [AW-1:0] memif_r0_addr,
  output logic          memif_r0_recv,
  input  logic          memif_r0_ack,
  output logic [31:0]   memif_r0_rdata,
  output logic          memif_r0_error,

  input  logic          memif_r1_req,
  output logic          memif_r1_gnt,
  input  logic          memif_r1_wen,
  input  logic [3:0]    memif_r1_strb,
  input  logic [31:0]   memif_r1_wdata,
  input  logic [AW-1:0] memif_r1_addr,
  output logic          memif_r1_recv,
  input  logic          memif_r1_ack,
  output logic [31:0]   memif_r1_rdata,
  output logic          memif_r1_error,

  output logic          memif_dev_req,
  input  logic          memif_dev_gnt,
  output logic          memif_dev_wen,
  output logic [3:0]    memif_dev_strb,
  output logic [31:0]   memif_dev_wdata,
  output logic [AW-1:0] memif_dev_addr,
  input  logic          memif_dev_recv,
  output logic          memif_dev_ack,
  input  logic [31:0]   memif_dev_rdata,
  input  logic          memif_dev_error
);

  periph_arb_state_t sel_state_q, sel_state_d;
  periph_arb_id_t    rr_last_q, rr_last_d;
  periph_arb_id_t    sel_id;
  periph_arb_id_t    fifo_head;
  logic              fifo_full, fifo_empty;
  logic              sel_req, dev_req, dev_xfer, rsp_xfer;

  // Requester selection: locked states pin the mux, IDLE arbitrates.
  always_comb begin
    sel_id = ARB_R0;
    case (sel_state_q)
      LOCK0:   sel_id = ARB_R0;
      LOCK1:   sel_id = ARB_R1;
      default: begin
        if (memif_r0_req && memif_r1_req) sel_id = ~rr_last_q;
        else if (memif_r1_req)            sel_id = ARB_R1;
        else                              sel_id = ARB_R0;
      end
    endcase
  end

  // Request mux. Full blocks req outright, independent of a same-cycle pop.
  always_comb begin
    sel_req  = (sel_id == ARB_R1) ? memif_r1_req : memif_r0_req;
    dev_req  = sel_req && !fifo_full;
    dev_xfer = dev_req && memif_dev_gnt;

    memif_dev_req   = dev_req;
    memif_dev_addr  = (sel_id == ARB_R1) ? memif_r1_addr  : memif_r0_addr;
    memif_dev_wen   = (sel_id == ARB_R1) ? memif_r1_wen   : memif_r0_wen;
    memif_dev_strb  = (sel_id == ARB_R1) ? memif_r1_strb  : memif_r0_strb;
    memif_dev_wdata = (sel_id == ARB_R1) ? memif_r1_wdata : memif_r0_wdata;

    memif_r0_gnt = dev_xfer && (sel_id == ARB_R0);
    memif_r1_gnt = dev_xfer && (sel_id == ARB_R1);
  end

  // Response steering. With nothing outstanding a stray recv is drained.
  always_comb begin
    memif_r0_recv = memif_dev_recv && !fifo_empty && (fifo_head == ARB_R0);
    memif_r1_recv = memif_dev_recv && !fifo_empty && (fifo_head == ARB_R1);
    if (fifo_empty)
      memif_dev_ack = memif_dev_recv;
    else
      memif_dev_ack = (fifo_head == ARB_R1) ? memif_r1_ack : memif_r0_ack;
    rsp_xfer = memif_dev_recv && memif_dev_ack && !fifo_empty;

    memif_r0_rdata = memif_dev_rdata;
    memif_r1_rdata = memif_dev_rdata;
    memif_r0_error = memif_dev_error;
    memif_r1_error = memif_dev_error;
  end

  always_comb begin
    sel_state_d = sel_state_q;
    rr_last_d   = rr_last_q;
    if (dev_xfer) rr_last_d = sel_id;
    case (sel_state_q)
      IDLE: begin
        if (sel_req && !dev_xfer)
          sel_state_d = (sel_id == ARB_R1) ? LOCK1 : LOCK0;
      end
      default: begin
        if (dev_xfer) sel_state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      sel_state_q <= IDLE;
      rr_last_q   <= ARB_R1;
    end else begin
      sel_state_q <= sel_state_d;
      rr_last_q   <= rr_last_d;
    end
  end

  scarv_soc_arb_id_fifo #(
    .DEPTH (OUTSTANDING)
  ) u_owner_fifo (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .push     (dev_xfer),
    .push_id  (sel_id),
    .pop      (rsp_xfer),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

`ifndef SYNTHESIS
  always_ff @(posedge g_clk) begin
    if (g_resetn) begin
      assert (!(memif_dev_recv && fifo_empty));
    end
  end
`endif

endmodule

// File: tb/tb_scarv_soc_periph_arb.sv
// Bench for scarv_soc_periph_arb: directed scenarios with a response scoreboard.
module tb_scarv_soc_periph_arb;
  import scarv_soc_pkg::*;

  localparam int AW = 32;

  logic          g_clk = 1'b0;
  logic          g_resetn = 1'b0;
  logic          r0_req, r0_gnt, r0_wen, r0_recv, r0_ack, r0_error;
  logic [3:0]    r0_strb;
  logic [31:0]   r0_wdata, r0_rdata;
  logic [AW-1:0] r0_addr;
  logic          r1_req, r1_gnt, r1_wen, r1_recv, r1_ack, r1_error;
  logic [3:0]    r1_strb;
  logic [31:0]   r1_wdata, r1_rdata;
  logic [AW-1:0] r1_addr;
  logic          dev_req, dev_gnt, dev_wen, dev_recv, dev_ack, dev_error;
  logic [3:0]    dev_strb;
  logic [31:0]   dev_wdata, dev_rdata;
  logic [AW-1:0] dev_addr;

  typedef struct {
    logic        id;
    logic [31:0] data;
  } sb_t;

  sb_t sb_q[$];
  sb_t mon_e;
  int  errors = 0;
  int  checks = 0;

  always #5 g_clk = ~g_clk;

  scarv_soc_periph_arb #(.OUTSTANDING(2), .AW(AW)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .memif_r0_req(r0_req), .memif_r0_gnt(r0_gnt), .memif_r0_wen(r0_wen),
    .memif_r0_strb(r0_strb), .memif_r0_wdata(r0_wdata), .memif_r0_addr(r0_addr),
    .memif_r0_recv(r0_recv), .memif_r0_ack(r0_ack), .memif_r0_rdata(r0_rdata),
    .memif_r0_error(r0_error),
    .memif_r1_req(r1_req), .memif_r1_gnt(r1_gnt), .memif_r1_wen(r1_wen),
    .memif_r1_strb(r1_strb), .memif_r1_wdata(r1_wdata), .memif_r1_addr(r1_addr),
    .memif_r1_recv(r1_recv), .memif_r1_ack(r1_ack), .memif_r1_rdata(r1_rdata),
    .memif_r1_error(r1_error),
    .memif_dev_req(dev_req), .memif_dev_gnt(dev_gnt), .memif_dev_wen(dev_wen),
    .memif_dev_strb(dev_strb), .memif_dev_wdata(dev_wdata), .memif_dev_addr(dev_addr),
    .memif_dev_recv(dev_recv), .memif_dev_ack(dev_ack), .memif_dev_rdata(dev_rdata),
    .memif_dev_error(dev_error)
  );

  // Scoreboard consumer: every device response must reach the recorded owner.
  always @(negedge g_clk) begin
    if (g_resetn && dev_recv) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_underflow: device recv with nothing expected");
      end else begin
        mon_e = sb_q.pop_front();
        if ({r1_recv, r0_recv} !== (mon_e.id ? 2'b10 : 2'b01) || dev_ack !== 1'b1 ||
            (mon_e.id ? r1_rdata : r0_rdata) !== mon_e.data) begin
          errors++;
          $display("FAIL rsp_route: r1/r0 recv=%b%b ack=%b rdata=%h, required owner r%0d ack=1 rdata=%h",
                   r1_recv, r0_recv, dev_ack, mon_e.id ? r1_rdata : r0_rdata, mon_e.id, mon_e.data);
        end
      end
    end
  end

  task automatic idle_inputs();
    r0_req = 0; r0_wen = 0; r0_strb = 4'hF; r0_wdata = '0; r0_addr = '0; r0_ack = 1;
    r1_req = 0; r1_wen = 0; r1_strb = 4'hF; r1_wdata = '0; r1_addr = '0; r1_ack = 1;
    dev_gnt = 0; dev_recv = 0; dev_rdata = '0; dev_error = 0;
  endtask

  task automatic next_cycle();
    @(posedge g_clk);
    #1;
  endtask

  task automatic apply_reset();
    g_resetn = 0;
    idle_inputs();
    next_cycle();
    next_cycle();
    sb_q.delete();
    g_resetn = 1;
  endtask

  task automatic sb_push(input logic id, input logic [31:0] data);
    sb_t e;
    e.id = id;
    e.data = data;
    sb_q.push_back(e);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      dev_recv = 1;
      dev_rdata = sb_q[0].data;
      @(negedge g_clk);
      next_cycle();
    end
    dev_recv = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    g_resetn = 0;
    dev_gnt = 1;
    next_cycle();
    next_cycle();
    @(negedge g_clk);
    checks++;
    if ({dev_req, r0_gnt, r1_gnt, r0_recv, r1_recv, dev_ack} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: req/g0/g1/rv0/rv1/ack=%b required 000000",
               {dev_req, r0_gnt, r1_gnt, r0_recv, r1_recv, dev_ack});
    end
    checks++;
    if (dut.u_owner_fifo.count_q !== 2'd0 || dut.sel_state_q !== IDLE || dut.rr_last_q !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: count=%0d state=%0d rr_last=%b required 0 0 1",
               dut.u_owner_fifo.count_q, dut.sel_state_q, dut.rr_last_q);
    end
    next_cycle();
    g_resetn = 1;
    @(negedge g_clk);
    checks++;
    if ({dev_req, r0_gnt, r1_gnt, dev_ack} !== 4'b0) begin
      errors++;
      $display("FAIL post_reset_quiet: req/g0/g1/ack=%b required 0000", {dev_req, r0_gnt, r1_gnt, dev_ack});
    end
    next_cycle();
  endtask

  task automatic test_single_read();
    apply_reset();
    r0_req = 1; r0_addr = 32'h1000_1004; dev_gnt = 1;
    sb_push(1'b0, 32'hDEAD_BEEF);
    @(negedge g_clk);
    checks++;
    if (dev_req !== 1 || dev_addr !== 32'h1000_1004 || r0_gnt !== 1 || r1_gnt !== 0) begin
      errors++;
      $display("FAIL single_grant: req=%b addr=%h g0=%b g1=%b required 1 10001004 1 0",
               dev_req, dev_addr, r0_gnt, r1_gnt);
    end
    next_cycle();
    r0_req = 0; dev_gnt = 0;
    @(negedge g_clk);
    checks++;
    if (r0_recv !== 0 || r1_recv !== 0 || dev_req !== 0) begin
      errors++;
      $display("FAIL single_gap: rv0=%b rv1=%b req=%b required 0 0 0", r0_recv, r1_recv, dev_req);
    end
    next_cycle();
    dev_recv = 1; dev_rdata = 32'hDEAD_BEEF;
    @(negedge g_clk);
    checks++;
    if (r0_recv !== 1 || r1_recv !== 0 || r1_gnt !== 0 || r0_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL single_resp: rv0=%b rv1=%b g1=%b rdata=%h required 1 0 0 deadbeef",
               r0_recv, r1_recv, r1_gnt, r0_rdata);
    end
    next_cycle();
    dev_recv = 0;
  endtask

  task automatic test_tie_alternation();
    logic want, prev;
    int   n0, n1;
    apply_reset();
    n0 = 0; n1 = 0; prev = 0;
    r0_req = 1; r0_addr = 32'h0000_A000;
    r1_req = 1; r1_addr = 32'h0000_B000;
    dev_gnt = 1;
    for (int k = 0; k < 5; k++) begin
      want = (k % 2 == 1);
      if (k >= 1) begin dev_recv = 1; dev_rdata = sb_q[0].data; end
      if (k < 4) sb_push(want, 32'h5000_0000 + k);
      @(negedge g_clk);
      if (k < 4) begin
        checks++;
        if ({r1_gnt, r0_gnt} !== (want ? 2'b10 : 2'b01) ||
            dev_addr !== (want ? r1_addr : r0_addr)) begin
          errors++;
          $display("FAIL tie_order[%0d]: g1g0=%b addr=%h required owner r%0d addr=%h",
                   k, {r1_gnt, r0_gnt}, dev_addr, want, want ? r1_addr : r0_addr);
        end
      end
      if (k >= 1) begin
        checks++;
        if (dut.fifo_head !== prev) begin
          errors++;
          $display("FAIL tie_fifo_head[%0d]: head=%b required %b", k, dut.fifo_head, prev);
        end
      end
      next_cycle();
      if (k < 4) begin
        prev = want;
        if (!want) begin
          n0++;
          if (n0 == 2) r0_req = 0; else r0_addr = r0_addr + 4;
        end else begin
          n1++;
          if (n1 == 2) r1_req = 0; else r1_addr = r1_addr + 4;
        end
      end
    end
    dev_recv = 0; dev_gnt = 0;
  endtask

  task automatic test_lock();
    apply_reset();
    r1_req = 1; r1_addr = 32'h2000_0010;
    r0_addr = 32'h3000_0020;
    for (int c = 0; c < 5; c++) begin
      if (c == 1) r0_req = 1;
      if (c == 3) begin dev_gnt = 1; sb_push(1'b1, 32'h0000_1111); end
      if (c == 4) sb_push(1'b0, 32'h0000_2222);
      @(negedge g_clk);
      checks++;
      if (c < 3) begin
        if (dev_req !== 1 || dev_addr !== 32'h2000_0010 || r0_gnt !== 0 || r1_gnt !== 0) begin
          errors++;
          $display("FAIL lock_hold[%0d]: req=%b addr=%h g0=%b g1=%b required 1 20000010 0 0",
                   c, dev_req, dev_addr, r0_gnt, r1_gnt);
        end
      end else if (c == 3) begin
        if (r1_gnt !== 1 || r0_gnt !== 0 || dev_addr !== 32'h2000_0010) begin
          errors++;
          $display("FAIL lock_grant_r1: g1=%b g0=%b addr=%h required 1 0 20000010", r1_gnt, r0_gnt, dev_addr);
        end
      end else begin
        if (r0_gnt !== 1 || r1_gnt !== 0 || dev_addr !== 32'h3000_0020) begin
          errors++;
          $display("FAIL lock_grant_r0: g0=%b g1=%b addr=%h required 1 0 30000020", r0_gnt, r1_gnt, dev_addr);
        end
      end
      if (c == 1) begin
        checks++;
        if (dut.sel_state_q !== LOCK1) begin
          errors++;
          $display("FAIL lock_state: state=%0d required %0d", dut.sel_state_q, LOCK1);
        end
      end
      next_cycle();
      if (c == 3) r1_req = 0;
      if (c == 4) r0_req = 0;
    end
    dev_gnt = 0;
    drain(2);
  endtask

  task automatic test_full_backpressure();
    logic want;
    apply_reset();
    dev_gnt = 1; r0_req = 1; r0_addr = 32'h4000_0000;
    for (int c = 0; c < 6; c++) begin
      want = (c < 2) || (c == 5);
      if (c == 4) begin dev_recv = 1; dev_rdata = sb_q[0].data; end
      else dev_recv = 0;
      if (want) sb_push(1'b0, 32'hF000_0000 + c);
      @(negedge g_clk);
      checks++;
      if (dev_req !== want || r0_gnt !== want) begin
        errors++;
        $display("FAIL full_block[%0d]: req=%b g0=%b required %b %b", c, dev_req, r0_gnt, want, want);
      end
      if (c == 3) begin
        checks++;
        if (dut.u_owner_fifo.count_q !== 2'd2) begin
          errors++;
          $display("FAIL full_count: count=%0d required 2", dut.u_owner_fifo.count_q);
        end
      end
      next_cycle();
      if (want) r0_addr = r0_addr + 4;
      if (c == 5) r0_req = 0;
    end
    dev_recv = 0; dev_gnt = 0;
    drain(2);
  endtask

  task automatic test_push_pop();
    apply_reset();
    dev_gnt = 1; r0_req = 1; r0_addr = 32'h5000_0000;
    sb_push(1'b0, 32'h1111_1111);
    @(negedge g_clk);
    next_cycle();
    r0_req = 0;
    r1_req = 1; r1_addr = 32'h6000_0000;
    dev_recv = 1; dev_rdata = sb_q[0].data;
    sb_push(1'b1, 32'h2222_2222);
    @(negedge g_clk);
    checks++;
    if (r1_gnt !== 1 || r0_recv !== 1 || dut.u_owner_fifo.count_q !== 2'd1) begin
      errors++;
      $display("FAIL pushpop_cycle: g1=%b rv0=%b count=%0d required 1 1 1",
               r1_gnt, r0_recv, dut.u_owner_fifo.count_q);
    end
    next_cycle();
    r1_req = 0; dev_recv = 0; dev_gnt = 0;
    @(negedge g_clk);
    checks++;
    if (dut.u_owner_fifo.count_q !== 2'd1 || dut.fifo_head !== 1'b1) begin
      errors++;
      $display("FAIL pushpop_after: count=%0d head=%b required 1 1",
               dut.u_owner_fifo.count_q, dut.fifo_head);
    end
    next_cycle();
    drain(1);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    dev_gnt = 1; r0_req = 1; r0_addr = 32'h7000_0000;
    next_cycle();
    r0_addr = 32'h7000_0004;
    next_cycle();
    r0_req = 0; r1_req = 1; r1_addr = 32'h8000_0000;
    @(negedge g_clk);
    checks++;
    if (dev_req !== 0 || r1_gnt !== 0) begin
      errors++;
      $display("FAIL mid_full: req=%b g1=%b required 0 0", dev_req, r1_gnt);
    end
    next_cycle();
    @(negedge g_clk);
    checks++;
    if (dut.sel_state_q !== LOCK1 || dut.u_owner_fifo.count_q !== 2'd2) begin
      errors++;
      $display("FAIL mid_prestate: state=%0d count=%0d required %0d 2",
               dut.sel_state_q, dut.u_owner_fifo.count_q, LOCK1);
    end
    next_cycle();
    g_resetn = 0; r1_req = 0;
    next_cycle();
    g_resetn = 1;
    sb_q.delete();
    @(negedge g_clk);
    checks++;
    if ({dev_req, r0_gnt, r1_gnt, r0_recv, r1_recv, dev_ack} !== 6'b0 ||
        dut.u_owner_fifo.count_q !== 2'd0 || dut.sel_state_q !== IDLE) begin
      errors++;
      $display("FAIL mid_reset: outs=%b count=%0d state=%0d required 000000 0 %0d",
               {dev_req, r0_gnt, r1_gnt, r0_recv, r1_recv, dev_ack},
               dut.u_owner_fifo.count_q, dut.sel_state_q, IDLE);
    end
    next_cycle();
    r0_req = 1; r1_req = 1; r0_addr = 32'h9000_0000; r1_addr = 32'h9100_0000;
    sb_push(1'b0, 32'h3333_3333);
    @(negedge g_clk);
    checks++;
    if (r0_gnt !== 1 || r1_gnt !== 0) begin
      errors++;
      $display("FAIL mid_tie: g0=%b g1=%b required 1 0", r0_gnt, r1_gnt);
    end
    next_cycle();
    r0_req = 0; r1_req = 0; dev_gnt = 0;
    drain(1);
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_read();
    test_tie_alternation();
    test_lock();
    test_full_backpressure();
    test_push_pop();
    test_reset_mid();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d responses never arrived, required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/scarv_soc_periph_arb.md
# scarv_soc_periph_arb

Two-requester arbiter sharing the single peripheral-subsystem memory port between the CPU data port and a second master (DMA or debug). Sits in front of the peripheral top-level router. It selects one requester per transaction, holds the selection stable until the device grants, and records the owner of every granted request so the in-order responses are steered back to the right requester. Adds no cycles to either channel; the request and response muxes are combinational.

## Interface
- `OUTSTANDING`, default 2: maximum granted-but-unresponded transactions; must be a power of two, at least 1.
- `AW`, default 32: address width carried on all three interfaces.
- `g_clk` input, 1 bit: single clock.
- `g_resetn` input, 1 bit: active-low reset, synchronous to `g_clk`.
- `memif_r0` scarv_ccx_memif.RSP: requester 0 (CPU). Wins ties after reset.
- `memif_r1` scarv_ccx_memif.RSP: requester 1 (DMA/debug).
- `memif_dev` scarv_ccx_memif.REQ: to the peripheral subsystem.
- Memif signals used: `req`, `gnt`, `wen`, `strb`, `wdata`, `addr`, `recv`, `ack`, `rdata`, `error`.

## Operation
- **Request channel rules (all three ports):**
  - A transfer occurs on a cycle with `req && gnt`.
  - Once `req` is high, `req`, `addr`, `wen`, `strb` and `wdata` stay stable until the transfer occurs.
- **Response channel rules:** the device returns responses in request order. A response transfers on a cycle with `recv && ack`.
- **State machine `sel_state`:**
  - States are IDLE and LOCK0 / LOCK1.
  - IDLE: if exactly one `rN.req` is high, pick it. If both are high, pick the requester not equal to `rr_last`.
  - If the picked request is not granted in the same cycle, go to LOCK(picked). This prevents switching away from a presented, ungranted request.
  - LOCKn: the mux stays on requester n regardless of the other requester. Return to IDLE on the cycle `memif_dev.gnt` is high.
  - If the request is granted in the IDLE cycle, stay in IDLE.
- **`rr_last`:** updated to the granted requester on every transfer. Resets to 1, so r0 wins the first tie.
- **Request mux:**
  - `memif_dev.req` equals the selected `rN.req`, gated low when the owner FIFO is full.
  - addr/wen/strb/wdata pass through from the selected requester.
  - `rN.gnt` equals `memif_dev.gnt` for the selected requester and 0 for the other.
  - While the FIFO is full, no `rN.gnt` is asserted.
- **Owner FIFO:**
  - Depth `OUTSTANDING`, 1-bit entries holding the requester ID.
  - Push the selected ID on each device transfer; pop on each device response transfer.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo `OUTSTANDING`. The count is $clog2(OUTSTANDING)+1 bits.
- **Full condition:** count == `OUTSTANDING`. The request is blocked even if a pop occurs in the same cycle, so there is no combinational path from ack to req.
- **Response steering:**
  - When the FIFO is non-empty, the head ID selects the target requester.
  - The target sees `recv` = `memif_dev.recv`; the other requester sees 0.
  - `memif_dev.ack` is the target's `ack`.
  - `rdata` and `error` broadcast to both requesters.
- **Empty FIFO:** a device `recv` is a protocol error. `memif_dev.ack` is driven 1 to drain it, no requester sees `recv`, and a simulation-only assertion fires.
- **Reset (g_resetn low at a rising edge):**
  - FIFO empties, `sel_state` goes to IDLE, `rr_last` goes to 1.
  - Outstanding transactions are discarded. The surrounding subsystem is reset on the same edge.

## Timing
- Zero added latency on both channels: gnt, recv and ack are combinational through the muxes.
- Registered state: `sel_state`, `rr_last`, FIFO storage, pointers and count. All update on the rising edge of `g_clk`.
- Output values during and straight after reset: `memif_dev.req`=0, `r0.gnt`=`r1.gnt`=0, `r0.recv`=`r1.recv`=0, `memif_dev.ack`=0. Each holds until a requester raises `req` or the device raises `recv`.
- Back-to-back throughput: one transfer per cycle per channel while the FIFO is not full.
- A grant and the response to an earlier transaction may occur in the same cycle.

## Structure
- Shared package `scarv_soc_pkg`:
  - typedef `periph_arb_id_t` (1 bit).
  - localparams `ARB_R0`=0, `ARB_R1`=1.
  - enum `periph_arb_state_t` {IDLE, LOCK0, LOCK1}.
- Sub-module `scarv_soc_arb_id_fifo`: parameterised-depth ID FIFO with push, pop, head, full and empty.
- Top-level module holds the selection FSM and the muxes.

## Test plan
- **Single-requester read, r0 only:** addr 0x1000_1004, device gnt in the same cycle, recv 2 cycles later with rdata 0xDEADBEEF. Required: r0 sees gnt and recv with that data; r1.gnt and r1.recv stay 0.
- **Tie and alternation:** both requesters hold req for 4 back-to-back transfers with gnt always high. Required grant order r0, r1, r0, r1; the FIFO holds the matching IDs; responses are routed in that order.
- **Lock:** r1 requests alone and the device holds gnt low for 3 cycles; r0 raises req in cycle 2. Required: mux stays on r1, addr stable, r1 granted in cycle 4, r0 granted next.
- **Full backpressure, `OUTSTANDING`=2:** 2 granted, no responses. Required: the third request sees `memif_dev.req`=0 until the first response transfers, and req returns the cycle after.
- **Simultaneous push/pop:** a transfer coincides with a response at count 1. Required: count stays 1 and the head advances to the new owner.
- **Reset mid-transaction:** `g_resetn` low with count 2 and state LOCK1. Required on the next cycle: all outputs 0, count 0, state IDLE, and r0 wins the next tie.
